// File: rtl/ay_write_sequencer.sv
// ay_write_sequencer
//   Register-write engine for a TurboSound AY pair. It drains a FIFO of
//   {chip,reg,data} writes onto the shared AY bus using the 0xFF/0xFE
//   chip-select convention. The bus is shared with the Z80: CPU latch/select
//   cycles are snooped while the bus is idle, and the CPU's selected chip and
//   latched register are put back at the end of every burst.
//
//   Optional feature (macro AYSEQ_SKIP_REDUNDANT_EN): a 2x16 shadow of the AY
//   registers is kept. A queued write whose value already matches the shadow
//   is dropped without any bus cycles. Register 13 (envelope shape) is always
//   written, because writing it retriggers the envelope.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   clken               bus tick strobe; the FSM and the AY bus only move on it
//   disable_turboay     1: queued writes to chip 1 are dropped
//   in_valid/in_ready   write request handshake (in_ready = FIFO not full)
//   in_chip/in_reg/in_data  request payload
//   cpu_bdir/cpu_bc1/cpu_din  snooped CPU AY bus
//   bus_own             1: external mux routes ay_* onto the AY bus
//   ay_bdir/ay_bc1/ay_dout    sequenced AY bus
//   cpu_wait            CPU is touching the AY bus while this block owns it
//   fifo_level          number of queued entries
module ay_write_sequencer #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clken,
    input  logic          disable_turboay,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_chip,
    input  logic [3:0]    in_reg,
    input  logic [7:0]    in_data,
    input  logic          cpu_bdir,
    input  logic          cpu_bc1,
    input  logic [7:0]    cpu_din,
    output logic          bus_own,
    output logic          ay_bdir,
    output logic          ay_bc1,
    output logic [7:0]    ay_dout,
    output logic          cpu_wait,
    output logic [AW:0]   fifo_level
);

    typedef struct packed {
        logic       chip;
        logic [3:0] rg;
        logic [7:0] data;
    } wr_t;

    // Each drive state is a single tick; GAP follows every drive tick and
    // uses the remembered previous phase to decide what comes next.
    typedef enum logic [2:0] {
        S_IDLE, S_SEL, S_ADDR, S_DATA, S_RSEL, S_RADDR, S_GAP
    } state_t;

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    // ---------------- FIFO ----------------
    wr_t           mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push, pop, empty;
    wr_t           head;

    assign empty    = (fifo_level == '0);
    assign in_ready = (fifo_level != FULL_LVL);
    assign push     = in_valid & in_ready;
    assign head     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{chip: in_chip, rg: in_reg, data: in_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // ---------------- CPU snoop ----------------
    logic       cpu_chip, cur_chip, cur_chip_nx;
    logic [7:0] cpu_addr;
    logic       snoop_lat, snoop_sel, snoop_wr;

    assign snoop_lat = ~bus_own & cpu_bdir & cpu_bc1;
    assign snoop_sel = snoop_lat & (cpu_din[7:1] == 7'h7F);
    assign snoop_wr  = ~bus_own & cpu_bdir & ~cpu_bc1;
    assign cpu_wait  = bus_own & (cpu_bdir | cpu_bc1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_chip <= 1'b0;
            cpu_addr <= 8'h00;
        end else if (snoop_sel) begin
            cpu_chip <= ~cpu_din[0];
        end else if (snoop_lat) begin
            cpu_addr <= cpu_din;
        end
    end

    // cur_chip is the chip actually selected on the AY bus. While idle the
    // CPU owns the bus, so its selects move it too; otherwise the FSM does.
    // No conflict: the FSM only pops when no CPU strobe is present.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            cur_chip <= 1'b0;
        else if (snoop_sel) cur_chip <= ~cpu_din[0];
        else if (clken)     cur_chip <= cur_chip_nx;
    end

    // ---------------- redundant-write filter ----------------
    logic   skip_hit;
    state_t state, state_nx, prev, prev_nx;
    wr_t    cur, cur_nx;

`ifdef AYSEQ_SKIP_REDUNDANT_EN
    logic [7:0] shadow [0:1][0:15];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < 2; c++)
                for (int r = 0; r < 16; r++)
                    shadow[c][r] <= 8'h00;
        end else if (state == S_DATA) begin
            shadow[cur.chip][cur.rg] <= cur.data;
        end else if (snoop_wr) begin
            shadow[cpu_chip][cpu_addr[3:0]] <= cpu_din;
        end
    end

    assign skip_hit = (head.rg != 4'd13) && (shadow[head.chip][head.rg] == head.data);
`else
    assign skip_hit = 1'b0;
`endif

    // ---------------- sequencer FSM ----------------
    logic       drop;
    logic       start_sel;
    logic [7:0] start_dout;
    logic       bus_own_nx, bdir_nx, bc1_nx;
    logic [7:0] dout_nx;

    assign drop       = (head.chip & disable_turboay) | skip_hit;
    assign start_sel  = (head.chip != cur_chip);
    assign start_dout = start_sel ? (head.chip ? 8'hFE : 8'hFF) : {4'h0, head.rg};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            prev    <= S_IDLE;
            cur     <= '0;
            bus_own <= 1'b0;
            ay_bdir <= 1'b0;
            ay_bc1  <= 1'b0;
            ay_dout <= 8'h00;
        end else if (clken) begin
            state   <= state_nx;
            prev    <= prev_nx;
            cur     <= cur_nx;
            bus_own <= bus_own_nx;
            ay_bdir <= bdir_nx;
            ay_bc1  <= bc1_nx;
            ay_dout <= dout_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        prev_nx     = prev;
        cur_nx      = cur;
        cur_chip_nx = cur_chip;
        bus_own_nx  = bus_own;
        bdir_nx     = 1'b0;
        bc1_nx      = 1'b0;
        dout_nx     = ay_dout;
        pop         = 1'b0;
        if (clken) begin
            case (state)
                S_IDLE: begin
                    if (!empty && !(cpu_bdir || cpu_bc1)) begin
                        pop = 1'b1;
                        if (!drop) begin
                            bus_own_nx  = 1'b1;
                            cur_nx      = head;
                            cur_chip_nx = head.chip;
                            state_nx    = start_sel ? S_SEL : S_ADDR;
                            bdir_nx     = 1'b1;
                            bc1_nx      = 1'b1;
                            dout_nx     = start_dout;
                        end
                    end
                end
                S_SEL, S_ADDR, S_DATA, S_RSEL, S_RADDR: begin
                    state_nx = S_GAP;
                    prev_nx  = state;
                end
                S_GAP: begin
                    case (prev)
                        S_SEL: begin
                            state_nx = S_ADDR;
                            bdir_nx  = 1'b1;
                            bc1_nx   = 1'b1;
                            dout_nx  = {4'h0, cur.rg};
                        end
                        S_ADDR: begin
                            state_nx = S_DATA;
                            bdir_nx  = 1'b1;
                            dout_nx  = cur.data;
                        end
                        S_DATA: begin
                            if (!empty) begin
                                // Keep the bus and chain the next entry; a
                                // dropped entry just costs this GAP one tick.
                                pop = 1'b1;
                                if (!drop) begin
                                    cur_nx      = head;
                                    cur_chip_nx = head.chip;
                                    state_nx    = start_sel ? S_SEL : S_ADDR;
                                    bdir_nx     = 1'b1;
                                    bc1_nx      = 1'b1;
                                    dout_nx     = start_dout;
                                end
                            end else if (cpu_chip != cur_chip) begin
                                cur_chip_nx = cpu_chip;
                                state_nx    = S_RSEL;
                                bdir_nx     = 1'b1;
                                bc1_nx      = 1'b1;
                                dout_nx     = cpu_chip ? 8'hFE : 8'hFF;
                            end else begin
                                state_nx = S_RADDR;
                                bdir_nx  = 1'b1;
                                bc1_nx   = 1'b1;
                                dout_nx  = cpu_addr;
                            end
                        end
                        S_RSEL: begin
                            state_nx = S_RADDR;
                            bdir_nx  = 1'b1;
                            bc1_nx   = 1'b1;
                            dout_nx  = cpu_addr;
                        end
                        default: begin
                            state_nx   = S_IDLE;
                            bus_own_nx = 1'b0;
                        end
                    endcase
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ay_write_sequencer.sv
module tb_ay_write_sequencer;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clken = 1'b0;
    logic          disable_turboay = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_chip = 1'b0;
    logic [3:0]    in_reg = 4'h0;
    logic [7:0]    in_data = 8'h00;
    logic          cpu_bdir = 1'b0;
    logic          cpu_bc1 = 1'b0;
    logic [7:0]    cpu_din = 8'h00;
    logic          bus_own, ay_bdir, ay_bc1, cpu_wait;
    logic [7:0]    ay_dout;
    logic [AW:0]   fifo_level;

    always #5 clk = ~clk;

    ay_write_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .clken(clken), .disable_turboay(disable_turboay),
        .in_valid(in_valid), .in_ready(in_ready), .in_chip(in_chip),
        .in_reg(in_reg), .in_data(in_data), .cpu_bdir(cpu_bdir), .cpu_bc1(cpu_bc1),
        .cpu_din(cpu_din), .bus_own(bus_own), .ay_bdir(ay_bdir), .ay_bc1(ay_bc1),
        .ay_dout(ay_dout), .cpu_wait(cpu_wait), .fifo_level(fifo_level)
    );

    typedef struct packed {
        logic       chip;
        logic [3:0] rg;
        logic [7:0] data;
    } wr_t;

    int          vectors = 0;
    int          miscompares = 0;
    int          bursts_seen = 0;
    int          exp_bursts = 0;
    wr_t         batch[$];
    logic [9:0]  exp_q[$];          // {bdir, bc1, dout} per bus write
    logic [9:0]  mon_e;
    logic        tick_q = 1'b0;
    logic        own_q = 1'b0;

    // reference state: what the AY chips and CPU have selected / latched
    bit          m_cur_chip, m_cpu_chip;
    logic [7:0]  m_cpu_addr;
    logic [7:0]  m_shadow [2][16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) tick_q <= clken && !rst;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus_own && !own_q) bursts_seen++;
            if (tick_q && (ay_bdir || ay_bc1)) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_strobe: got bdir=%b bc1=%b dout=%h expected no write",
                             ay_bdir, ay_bc1, ay_dout);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("bus_write", {bus_own, ay_bdir, ay_bc1, ay_dout}, {1'b1, mon_e});
                end
            end
        end
        own_q = bus_own;
    end

    // ---------------- reference model ----------------
    task automatic model_reset();
        m_cur_chip = 0;
        m_cpu_chip = 0;
        m_cpu_addr = 8'h00;
        for (int c = 0; c < 2; c++)
            for (int r = 0; r < 16; r++)
                m_shadow[c][r] = 8'h00;
        exp_q.delete();
    endtask

    // A batch loaded while clken=0 drains as a single burst (or none).
    task automatic model_batch(input bit dis);
        int  kept;
        wr_t w;
        kept = 0;
        foreach (batch[i]) begin
            w = batch[i];
            if (w.chip && dis) continue;
`ifdef AYSEQ_SKIP_REDUNDANT_EN
            if (w.rg != 4'd13 && m_shadow[w.chip][w.rg] == w.data) continue;
`endif
            kept++;
            if (w.chip != m_cur_chip) begin
                exp_q.push_back({2'b11, (w.chip ? 8'hFE : 8'hFF)});
                m_cur_chip = w.chip;
            end
            exp_q.push_back({2'b11, 4'h0, w.rg});
            exp_q.push_back({2'b10, w.data});
            m_shadow[w.chip][w.rg] = w.data;
        end
        if (kept > 0) begin
            if (m_cpu_chip != m_cur_chip) begin
                exp_q.push_back({2'b11, (m_cpu_chip ? 8'hFE : 8'hFF)});
                m_cur_chip = m_cpu_chip;
            end
            exp_q.push_back({2'b11, m_cpu_addr});
            exp_bursts++;
        end
    endtask

    // ---------------- stimulus helpers (all start at posedge+1) ----------------
    task automatic push_one(input wr_t w);
        check("in_ready_before_push", in_ready, 1);
        in_valid = 1'b1;
        in_chip  = w.chip;
        in_reg   = w.rg;
        in_data  = w.data;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic load_batch();
        clken = 1'b0;
        foreach (batch[i]) push_one(batch[i]);
    endtask

    task automatic drain(input bit probe);
        bit done, probed;
        done = 0;
        probed = 0;
        for (int c = 0; c < 3000 && !done; c++) begin
            clken = ($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
            if (probe && !probed && bus_own) begin
                cpu_bdir = 1'b1;
                cpu_bc1  = 1'($urandom_range(0, 1));
                #1;
                check("cpu_wait_mid_burst", cpu_wait, 1);
                cpu_bdir = 1'b0;
                cpu_bc1  = 1'b0;
                probed = 1;
            end
            if (fifo_level == 0 && !bus_own) done = 1;
        end
        clken = 1'b0;
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got level=%0d bus_own=%b expected idle", fifo_level, bus_own);
        end
    endtask

    task automatic finish_batch(input bit dis, input bit probe);
        model_batch(dis);
        drain(probe);
        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        check("burst_count", bursts_seen, exp_bursts);
        batch.delete();
    endtask

    task automatic run_batch(input bit dis, input bit probe);
        disable_turboay = dis;
        load_batch();
        finish_batch(dis, probe);
        disable_turboay = 1'b0;
    endtask

    task automatic cpu_latch(input logic [7:0] v);
        cpu_bdir = 1'b1; cpu_bc1 = 1'b1; cpu_din = v;
        @(posedge clk); #1;
        cpu_bdir = 1'b0; cpu_bc1 = 1'b0;
        if (v[7:1] == 7'h7F) begin
            m_cpu_chip = ~v[0];
            m_cur_chip = m_cpu_chip;
        end else begin
            m_cpu_addr = v;
        end
    endtask

    task automatic cpu_write(input logic [7:0] v);
        cpu_bdir = 1'b1; cpu_bc1 = 1'b0; cpu_din = v;
        @(posedge clk); #1;
        cpu_bdir = 1'b0;
        m_shadow[m_cpu_chip][m_cpu_addr[3:0]] = v;
    endtask

    // ---------------- main sequence ----------------
    int rise, fall;

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("reset_outputs", {in_ready, bus_own, ay_bdir, ay_bc1, ay_dout, cpu_wait},
              {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0});
        check("reset_level", fifo_level, 0);

        // 1: single write, continuous clken, latency
        batch.push_back('{chip: 1'b0, rg: 4'd7, data: 8'h38});
        model_batch(1'b0);
        clken = 1'b1;
        in_valid = 1'b1; in_chip = 1'b0; in_reg = 4'd7; in_data = 8'h38;
        @(posedge clk); #1;                 // push tick T
        in_valid = 1'b0;
        rise = -1; fall = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 1) check("addr_at_T1", {ay_bdir, ay_bc1, ay_dout}, {2'b11, 8'h07});
            if (k == 3) check("data_at_T3", {ay_bdir, ay_bc1, ay_dout}, {2'b10, 8'h38});
            if (k == 5) check("raddr_at_T5", {ay_bdir, ay_bc1, ay_dout}, {2'b11, 8'h00});
            if (bus_own && rise < 0) rise = k;
            if (!bus_own && rise >= 0 && fall < 0) fall = k;
        end
        clken = 1'b0;
        check("bus_own_rise_tick", rise, 1);
        check("bus_own_fall_tick", fall, 7);
        check("queue_drained", exp_q.size(), 0);
        batch.delete();

        // 2: chip switch inside one burst
        batch.push_back('{chip: 1'b1, rg: 4'd8, data: 8'h0F});
        batch.push_back('{chip: 1'b0, rg: 4'd8, data: 8'h0A});
        run_batch(1'b0, 1'b0);

        // 3: overfill with clken=0
        for (int i = 0; i < DEPTH; i++)
            batch.push_back('{chip: 1'b0, rg: 4'(i), data: 8'(8'h40 + i)});
        load_batch();
        in_valid = 1'b1; in_chip = 1'b0; in_reg = 4'd9; in_data = 8'hA9;
        @(posedge clk); #1;
        check("full_in_ready", in_ready, 0);
        check("full_level", fifo_level, DEPTH);
        in_valid = 1'b0;
        finish_batch(1'b0, 1'b0);
        batch.push_back('{chip: 1'b0, rg: 4'd9, data: 8'hA9});
        batch.push_back('{chip: 1'b0, rg: 4'd10, data: 8'hAA});
        run_batch(1'b0, 1'b0);

        // 4: CPU selects chip 1 / reg 5, then a chip-0 write; probe cpu_wait
        cpu_latch(8'hFE);
        cpu_latch(8'h05);
        batch.push_back('{chip: 1'b0, rg: 4'd1, data: 8'h22});
        run_batch(1'b0, 1'b1);

        // 5: chip-1 write with TurboAY disabled
        batch.push_back('{chip: 1'b1, rg: 4'd0, data: 8'h55});
        run_batch(1'b1, 1'b0);

        // 6: repeated writes (redundant filter when enabled)
        batch.push_back('{chip: 1'b0, rg: 4'd3, data: 8'h11});
        batch.push_back('{chip: 1'b0, rg: 4'd3, data: 8'h11});
        batch.push_back('{chip: 1'b0, rg: 4'd13, data: 8'h0E});
        batch.push_back('{chip: 1'b0, rg: 4'd13, data: 8'h0E});
        run_batch(1'b0, 1'b0);

        // random batches with CPU activity in between
        for (int b = 0; b < 16; b++) begin
            if ($urandom_range(0, 1) == 1) begin
                case ($urandom_range(0, 2))
                    0:       cpu_latch(8'hFE);
                    1:       cpu_latch(8'hFF);
                    default: cpu_latch(8'($urandom_range(0, 15)));
                endcase
                if ($urandom_range(0, 1) == 1) cpu_write(8'($urandom_range(0, 3)));
            end
            for (int i = 0, n = $urandom_range(1, DEPTH); i < n; i++)
                batch.push_back('{chip: 1'($urandom_range(0, 1)),
                                  rg:   4'($urandom_range(0, 15)),
                                  data: 8'($urandom_range(0, 3))});
            run_batch(($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));
        end

        // reset in the middle of a DATA phase
        batch.push_back('{chip: 1'b0, rg: 4'd5, data: 8'h77});
        model_batch(1'b0);
        push_one(batch[0]);
        batch.delete();
        clken = 1'b1;
        rise = 0;
        for (int k = 0; k < 40 && rise == 0; k++) begin
            @(posedge clk); #1;
            if (ay_bdir && !ay_bc1) rise = 1;
        end
        check("reached_data_phase", rise, 1);
        rst = 1'b1;
        #1;
        check("rst_mid_burst_outputs", {bus_own, ay_bdir, ay_bc1, ay_dout, cpu_wait, in_ready},
              {1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1});
        check("rst_mid_burst_level", fifo_level, 0);
        clken = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // operation resumes cleanly after the abort
        batch.push_back('{chip: 1'b1, rg: 4'd2, data: 8'h5A});
        run_batch(1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected completion within 500us");
        $fatal(1);
    end

endmodule
